// File: rtl/fft8_bitrev_buffer.sv
// Bit-reversal reorder buffer feeding the 8-point FFT butterfly array.
// Two ping-pong banks: one fills in natural order while the other drains bit-reversed.

module fft8_bitrev_bank #(
  parameter int SIZE_DATA = 32,
  parameter int N_POINT   = 8,
  parameter int LOG2N     = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_wr_en,
  input  logic [LOG2N-1:0]     i_wr_addr,
  input  logic [SIZE_DATA-1:0] i_wr_re,
  input  logic [SIZE_DATA-1:0] i_wr_im,
  input  logic                 i_wr_last,
  input  logic                 i_rd_done,
  input  logic [LOG2N-1:0]     i_rd_addr,
  output logic                 o_full,
  output logic [SIZE_DATA-1:0] o_rd_re,
  output logic [SIZE_DATA-1:0] o_rd_im
);
  typedef enum logic {BANK_EMPTY = 1'b0, BANK_FULL = 1'b1} bank_st_e;

  bank_st_e             state_q;
  logic [SIZE_DATA-1:0] mem_re_q [N_POINT];
  logic [SIZE_DATA-1:0] mem_im_q [N_POINT];

  // Writes only land while EMPTY and drains only happen while FULL, so the two never collide.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= BANK_EMPTY;
      for (int i = 0; i < N_POINT; i++) begin
        mem_re_q[i] <= '0;
        mem_im_q[i] <= '0;
      end
    end else begin
      if (i_wr_en) begin
        mem_re_q[i_wr_addr] <= i_wr_re;
        mem_im_q[i_wr_addr] <= i_wr_im;
        if (i_wr_last) state_q <= BANK_FULL;
      end
      if (i_rd_done) state_q <= BANK_EMPTY;
    end
  end

  assign o_full  = (state_q == BANK_FULL);
  assign o_rd_re = mem_re_q[i_rd_addr];
  assign o_rd_im = mem_im_q[i_rd_addr];
endmodule

module fft8_bitrev_buffer #(
  parameter int SIZE_DATA = 32,
  parameter int N_POINT   = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [SIZE_DATA-1:0]         i_data_re,
  input  logic [SIZE_DATA-1:0]         i_data_im,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [SIZE_DATA-1:0]         o_data_re,
  output logic [SIZE_DATA-1:0]         o_data_im,
  output logic [$clog2(N_POINT)-1:0]   o_index,
  output logic                         o_last
);
  localparam int LOG2N = $clog2(N_POINT);
  localparam logic [LOG2N-1:0] CNT_MAX = LOG2N'(N_POINT - 1);

  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
  logic [LOG2N-1:0] rd_cnt_q, rd_cnt_d;

  logic                       wr_fire, wr_last, rd_fire, rd_last;
  logic [1:0]                 full, wr_en, rd_done;
  logic [1:0][SIZE_DATA-1:0]  bank_re, bank_im;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
    return r;
  endfunction

  assign wr_fire = i_valid & o_ready;
  assign wr_last = (wr_cnt_q == CNT_MAX);
  assign rd_fire = o_valid & i_ready;
  assign rd_last = (rd_cnt_q == CNT_MAX);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign wr_en[b]   = wr_fire & (wr_bank_q == 1'(b));
    assign rd_done[b] = rd_fire & rd_last & (rd_bank_q == 1'(b));

    fft8_bitrev_bank #(
      .SIZE_DATA (SIZE_DATA),
      .N_POINT   (N_POINT),
      .LOG2N     (LOG2N)
    ) u_bank (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_wr_en   (wr_en[b]),
      .i_wr_addr (wr_cnt_q),
      .i_wr_re   (i_data_re),
      .i_wr_im   (i_data_im),
      .i_wr_last (wr_last),
      .i_rd_done (rd_done[b]),
      .i_rd_addr (o_index),
      .o_full    (full[b]),
      .o_rd_re   (bank_re[b]),
      .o_rd_im   (bank_im[b])
    );
  end

  // Handshake outputs come straight from registered state: no i_valid/i_ready feedthrough.
  assign o_ready   = ~full[wr_bank_q];
  assign o_valid   = full[rd_bank_q];
  assign o_index   = bitrev(rd_cnt_q);
  assign o_last    = o_valid & rd_last;
  assign o_data_re = bank_re[rd_bank_q];
  assign o_data_im = bank_im[rd_bank_q];

  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    rd_cnt_d  = rd_cnt_q;
    rd_bank_d = rd_bank_q;
    if (wr_fire) begin
      wr_cnt_d = wr_last ? '0 : wr_cnt_q + 1'b1;
      if (wr_last) wr_bank_d = ~wr_bank_q;
    end
    if (rd_fire) begin
      rd_cnt_d = rd_last ? '0 : rd_cnt_q + 1'b1;
      if (rd_last) rd_bank_d = ~rd_bank_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_cnt_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_cnt_q  <= '0;
      rd_bank_q <= 1'b0;
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      wr_bank_q <= wr_bank_d;
      rd_cnt_q  <= rd_cnt_d;
      rd_bank_q <= rd_bank_d;
    end
  end
endmodule

// File: tb/tb_fft8_bitrev_buffer.sv
// Scoreboard bench for fft8_bitrev_buffer: frames are queued in bit-reversed order as
// they are accepted; a negedge monitor pops and compares every output transfer.

module tb_fft8_bitrev_buffer;
  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] i_data_re = '0;
  logic [31:0] i_data_im = '0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic [31:0] o_data_re;
  logic [31:0] o_data_im;
  logic [2:0]  o_index;
  logic        o_last;

  always #5 i_clk = ~i_clk;

  fft8_bitrev_buffer #(.SIZE_DATA(32), .N_POINT(8)) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_data_re (i_data_re),
    .i_data_im (i_data_im),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_data_re (o_data_re),
    .o_data_im (o_data_im),
    .o_index   (o_index),
    .o_last    (o_last)
  );

  typedef struct packed {
    logic [31:0] re;
    logic [31:0] im;
    logic [2:0]  idx;
    logic        last;
  } beat_t;

  beat_t       sb_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] fr_re [8];
  logic [31:0] fr_im [8];
  int          pcnt = 0;
  int          cyc = 0;
  bit          rand_rdy = 0;
  bit          meas_on = 0, meas_rdy = 0;
  int          first_cyc = -1, last_cyc = -1, beats = 0;
  bit          hold_v = 0;
  beat_t       hold_val, cur, e;

  // Output position k carries natural-order sample br(k) (hand table for N=8).
  function automatic int br(input int k);
    case (k)
      0: return 0; 1: return 4; 2: return 2; 3: return 6;
      4: return 1; 5: return 5; 6: return 3; default: return 7;
    endcase
  endfunction

  function automatic logic [31:0] fl(input int k);
    case (k)
      0: return 32'h0000_0000; 1: return 32'h3F80_0000; 2: return 32'h4000_0000;
      3: return 32'h4040_0000; 4: return 32'h4080_0000; 5: return 32'h40A0_0000;
      6: return 32'h40C0_0000; default: return 32'h40E0_0000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  always @(posedge i_clk) cyc++;

  always @(negedge i_clk) begin
    if (i_rst_n !== 1'b1) begin
      hold_v = 0;
    end else begin
      cur = '{re: o_data_re, im: o_data_im, idx: o_index, last: o_last};
      if (hold_v) chk("hold_stable", 128'(cur), 128'(hold_val));
      hold_v   = o_valid & ~i_ready;
      hold_val = cur;
      if (o_valid && i_ready) begin
        if (sb_q.size() == 0) fail_now("unexpected_output");
        else begin
          e = sb_q.pop_front();
          chk("out_beat", 128'(cur), 128'(e));
        end
        if (meas_on) begin
          if (first_cyc < 0) first_cyc = cyc;
          last_cyc = cyc;
          beats++;
        end
      end
      if (meas_rdy) chk("ready_stream", 128'(o_ready), 128'(1'b1));
      if (i_valid && o_ready) begin
        fr_re[pcnt] = i_data_re;
        fr_im[pcnt] = i_data_im;
        pcnt++;
        if (pcnt == 8) begin
          for (int k = 0; k < 8; k++)
            sb_q.push_back('{re: fr_re[br(k)], im: fr_im[br(k)], idx: 3'(br(k)), last: (k == 7)});
          pcnt = 0;
        end
      end
    end
  end

  task automatic tick_rdy();
    if (rand_rdy) i_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Called from posedge+1; returns at posedge+1 after the sample is accepted.
  task automatic send(input logic [31:0] re, input logic [31:0] im);
    i_valid   = 1'b1;
    i_data_re = re;
    i_data_im = im;
    for (int t = 0; t < 400; t++) begin
      @(negedge i_clk);
      if (o_ready) begin
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        tick_rdy();
        return;
      end
      @(posedge i_clk); #1;
      tick_rdy();
    end
    i_valid = 1'b0;
    fail_now("send_timeout");
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    repeat (n) begin
      @(posedge i_clk); #1;
      tick_rdy();
    end
  endtask

  task automatic drain();
    rand_rdy = 0;
    i_ready  = 1'b1;
    for (int t = 0; t < 300 && sb_q.size() != 0; t++) begin
      @(posedge i_clk); #1;
    end
    chk("drain_queue_empty", 128'(sb_q.size()), 128'(0));
    chk("drain_valid_low", 128'(o_valid), 128'(1'b0));
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    #1;
    chk("reset_outputs", {o_ready, o_valid, o_last, o_index, o_data_re, o_data_im},
        {1'b1, 1'b0, 1'b0, 3'd0, 64'd0});
    sb_q.delete();
    pcnt   = 0;
    hold_v = 0;
    repeat (2) @(negedge i_clk);
    #1 i_rst_n = 1'b1;
    @(posedge i_clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout (t=%0t)", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // 1: float ramp, im = -re
    i_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("fill_no_valid", 128'(o_valid), 128'(1'b0));
      send(fl(k), fl(k) ^ 32'h8000_0000);
    end
    chk("first_out", {o_valid, o_index, o_last, o_data_re, o_data_im},
        {1'b1, 3'd0, 1'b0, 32'h0000_0000, 32'h8000_0000});
    drain();

    // 2: four back-to-back frames, gapless output, o_ready never drops
    meas_on = 1; meas_rdy = 1; first_cyc = -1; beats = 0;
    for (int k = 0; k < 32; k++) send(32'h1000_0000 + 32'(k), 32'h2000_0000 + 32'(k));
    meas_rdy = 0;
    drain();
    meas_on = 0;
    chk("stream_beats", 128'(beats), 128'(32));
    chk("stream_gapless", 128'(last_cyc - first_cyc + 1), 128'(32));

    // 3: downstream stalled while two frames fill
    i_ready = 1'b0;
    for (int k = 0; k < 16; k++) send(32'h3000_0000 + 32'(k), 32'h4000_0000 + 32'(k));
    i_valid = 1'b1; i_data_re = 32'h3000_0010; i_data_im = 32'h4000_0010;
    repeat (4) begin
      @(negedge i_clk);
      chk("stall_state", {o_ready, o_valid, o_index, o_data_re, o_data_im},
          {1'b0, 1'b1, 3'd0, 32'h3000_0000, 32'h4000_0000});
    end
    @(posedge i_clk); #1;
    i_ready = 1'b1;
    for (int k = 16; k < 24; k++) send(32'h3000_0000 + 32'(k), 32'h4000_0000 + 32'(k));
    drain();

    // 4: random valid/ready over 100 frames
    rand_rdy = 1;
    for (int f = 0; f < 100; f++)
      for (int k = 0; k < 8; k++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        send($urandom, $urandom);
      end
    drain();

    // 5: reset with a full frame mid-drain and a partial frame in the other bank
    i_ready = 1'b0;
    for (int k = 0; k < 13; k++) send(32'h5000_0000 + 32'(k), 32'h6000_0000 + 32'(k));
    i_ready = 1'b1;
    idle(3);
    do_reset();
    for (int k = 0; k < 8; k++) send(32'h7000_0000 + 32'(k), 32'h0800_0000 + 32'(k));
    chk("post_reset_first", {o_valid, o_index, o_data_re}, {1'b1, 3'd0, 32'h7000_0000});
    drain();

    // 6: special float patterns pass through untouched
    send(32'h7FC0_0000, 32'h0000_0001);
    send(32'h7F80_0000, 32'hFF80_0000);
    send(32'h0000_0001, 32'h7FC0_0000);
    send(32'hFF80_0000, 32'h7F80_0000);
    send(32'h7FA0_0000, 32'h8000_0001);
    send(32'h8000_0001, 32'h7FA0_0000);
    send(32'h7F7F_FFFF, 32'h0080_0000);
    send(32'h0080_0000, 32'h7F7F_FFFF);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
